// File: rtl/mem_a_skew_buf_if.sv
// Host/feeder bundle for the skewed A-operand buffer: row writes, swap/start
// handshake and the per-row operand stream toward the systolic array.
interface mem_a_skew_buf_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWS    = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                            wr_en;
  logic [RW-1:0]                   wr_row;
  logic [DIM-1:0][BITS_AB-1:0]     wr_data;
  logic                            swap;
  logic                            swap_ack;
  logic                            start;
  logic                            en;
  logic                            busy;
  logic                            done;
  logic [ROWS-1:0][BITS_AB-1:0]    Aout;
  logic [ROWS-1:0]                 Aout_vld;

  modport master (
    output wr_en, wr_row, wr_data, swap, start, en,
    input  swap_ack, busy, done, Aout, Aout_vld
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap, start, en,
    output swap_ack, busy, done, Aout, Aout_vld
  );
endinterface

// File: rtl/mem_a_skew_buf.sv
// Ping-pong A-tile buffer: host fills the shadow bank while the active bank
// streams out as a diagonal wavefront (row r lagging r cycles when SKEW=1).
module mem_a_skew_buf #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROWS    = 8,
  parameter int SKEW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_a_skew_buf_if.slave  bus
);
  localparam int L  = DIM + SKEW * (ROWS - 1);
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                        state_reg, state_next;
  logic [CW-1:0]                 cnt_reg, cnt_next;
  logic                          sel_reg, sel_next;
  logic                          pend_reg, pend_next;
  logic [DIM-1:0][BITS_AB-1:0]   bank0_reg [ROWS];
  logic [DIM-1:0][BITS_AB-1:0]   bank1_reg [ROWS];
  logic [ROWS-1:0][BITS_AB-1:0]  aout_reg, aout_next, row_val;
  logic [ROWS-1:0]               vld_reg, vld_next, row_hit;
  logic                          done_reg, done_next;
  logic                          ack_reg;
  logic                          do_swap;
  logic                          wr_ok;
  logic                          last;

  assign last    = (cnt_reg == CNT_LAST);
  // A swap is only ever performed from IDLE, either fresh or deferred from a stream.
  assign do_swap = (state_reg == IDLE) && (bus.swap || pend_reg);
  assign wr_ok   = bus.wr_en && (int'(bus.wr_row) < ROWS);

  // Writes always hit the bank that is not currently selected (pre-swap shadow).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        bank0_reg[r] <= '0;
        bank1_reg[r] <= '0;
      end
    end else if (wr_ok) begin
      for (int r = 0; r < ROWS; r++) begin
        if (bus.wr_row == RW'(r)) begin
          if (sel_reg) bank0_reg[r] <= bus.wr_data;
          else         bank1_reg[r] <= bus.wr_data;
        end
      end
    end
  end

  // Per-row element pick: column k = cnt - SKEW*row, blank outside 0..DIM-1.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    localparam int OFS = SKEW * gi;
    int                            k;
    logic [DIM-1:0][BITS_AB-1:0]   act_row;
    logic                          hit;
    logic [BITS_AB-1:0]            val;

    assign k       = int'(cnt_reg) - OFS;
    assign act_row = sel_reg ? bank1_reg[gi] : bank0_reg[gi];

    always_comb begin
      hit = (k >= 0) && (k < DIM);
      val = '0;
      for (int c = 0; c < DIM; c++) begin
        if (k == c) val = act_row[c];
      end
    end

    assign row_hit[gi] = hit;
    assign row_val[gi] = val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sel_reg   <= 1'b0;
      pend_reg  <= 1'b0;
      aout_reg  <= '0;
      vld_reg   <= '0;
      done_reg  <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      pend_reg  <= pend_next;
      aout_reg  <= aout_next;
      vld_reg   <= vld_next;
      done_reg  <= done_next;
      ack_reg   <= do_swap;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        if (do_swap) begin
          sel_next  = ~sel_reg;
          pend_next = 1'b0;
        end
        if (bus.start) begin
          state_next = STREAM;
          cnt_next   = '0;
        end
      end
      STREAM: begin
        if (bus.swap) pend_next = 1'b1;
        if (bus.en) begin
          if (last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    aout_next = aout_reg;
    vld_next  = vld_reg;
    done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        aout_next = '0;
        vld_next  = '0;
      end
      STREAM: begin
        if (bus.en) begin
          aout_next = row_val;
          vld_next  = row_hit;
          done_next = last;
        end
      end
      default: begin
        aout_next = '0;
        vld_next  = '0;
      end
    endcase
  end

  assign bus.busy     = (state_reg == STREAM);
  assign bus.done     = done_reg;
  assign bus.swap_ack = ack_reg;
  assign bus.Aout     = aout_reg;
  assign bus.Aout_vld = vld_reg;
endmodule

// File: tb/tb_mem_a_skew_buf.sv
// Directed bench: a 4x4 skewed instance and a 3-row unskewed instance
// checked cycle by cycle against hand-computed wavefront tables.
module tb_mem_a_skew_buf;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_a_skew_buf_if #(.BITS_AB(8), .DIM(4), .ROWS(4)) ia ();
  mem_a_skew_buf_if #(.BITS_AB(8), .DIM(4), .ROWS(3)) ib ();

  mem_a_skew_buf #(.BITS_AB(8), .DIM(4), .ROWS(4), .SKEW(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  mem_a_skew_buf #(.BITS_AB(8), .DIM(4), .ROWS(3), .SKEW(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  // Rows listed r3..r0 (high byte = row 3); entry n-1 is cycle n after start.
  logic [31:0] tile_tbl [7] = '{32'h00000000, 32'h00000A01, 32'h00140B02, 32'h1E150C03,
                                32'h1F160D00, 32'h20170000, 32'h21000000};
  logic [31:0] neg_tbl  [7] = '{32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFF00, 32'hFFFF0000, 32'hFF000000};
  logic [31:0] mix_tbl  [7] = '{32'h00000063, 32'h00000A63, 32'h00140B63, 32'h1E150C63,
                                32'h1F160D00, 32'h20170000, 32'h21000000};
  logic [3:0]  vld_tbl  [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [23:0] b_tbl    [4] = '{24'h211101, 24'h221202, 24'h231303, 24'h241404};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  // 0: all-zero tile, 1: decimal tile, 2: all -1 tile, 3: tile with row0=0x63
  task automatic stream_a(input int which, input string name);
    logic [31:0] exp;
    for (int n = 1; n <= 7; n++) begin
      step();
      case (which)
        1:       exp = tile_tbl[n-1];
        2:       exp = neg_tbl[n-1];
        3:       exp = mix_tbl[n-1];
        default: exp = 32'h0;
      endcase
      check($sformatf("%s c%0d aout", name, n), ia.Aout, exp);
      check($sformatf("%s c%0d vld", name, n), ia.Aout_vld, vld_tbl[n-1]);
      check($sformatf("%s c%0d done", name, n), ia.done, (n == 7));
    end
    check($sformatf("%s busy_end", name), ia.busy, 0);
  endtask

  task automatic start_a();
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ia.wr_en = 1'b0; ia.wr_row = '0; ia.wr_data = '0; ia.swap = 1'b0; ia.start = 1'b0; ia.en = 1'b1;
    ib.wr_en = 1'b0; ib.wr_row = '0; ib.wr_data = '0; ib.swap = 1'b0; ib.start = 1'b0; ib.en = 1'b1;

    step();
    step();
    check("rst aout", ia.Aout, 0);
    check("rst vld", ia.Aout_vld, 0);
    check("rst busy", ia.busy, 0);
    check("rst done", ia.done, 0);
    check("rst ack", ia.swap_ack, 0);
    rst = 1'b0;

    start_a();
    check("zero busy", ia.busy, 1);
    stream_a(0, "zero");

    step();
    for (int r = 0; r < 4; r++) begin
      ia.wr_en  = 1'b1;
      ia.wr_row = 2'(r);
      for (int c = 0; c < 4; c++) ia.wr_data[c] = 8'(10 * r + c);
      step();
    end
    ia.wr_en = 1'b0;
    ia.swap  = 1'b1;
    step();
    ia.swap = 1'b0;
    check("swap ack", ia.swap_ack, 1);
    step();
    check("swap ack_clr", ia.swap_ack, 0);

    start_a();
    stream_a(1, "tile");
    step();
    check("tile idle aout", ia.Aout, 0);
    check("tile idle vld", ia.Aout_vld, 0);

    start_a();
    for (int n = 1; n <= 3; n++) begin
      step();
      check($sformatf("stall c%0d aout", n), ia.Aout, tile_tbl[n-1]);
    end
    ia.en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall hold%0d aout", s), ia.Aout, tile_tbl[2]);
      check($sformatf("stall hold%0d vld", s), ia.Aout_vld, vld_tbl[2]);
      check($sformatf("stall hold%0d done", s), ia.done, 0);
      check($sformatf("stall hold%0d busy", s), ia.busy, 1);
    end
    ia.en = 1'b1;
    for (int n = 4; n <= 7; n++) begin
      step();
      check($sformatf("stall c%0d aout", n), ia.Aout, tile_tbl[n-1]);
      check($sformatf("stall c%0d done", n), ia.done, (n == 7));
    end

    start_a();
    for (int n = 1; n <= 7; n++) begin
      step();
      ia.wr_en = 1'b0;
      ia.swap  = 1'b0;
      check($sformatf("pp c%0d aout", n), ia.Aout, tile_tbl[n-1]);
      check($sformatf("pp c%0d ack", n), ia.swap_ack, 0);
      if (n <= 4) begin
        ia.wr_en  = 1'b1;
        ia.wr_row = 2'(n - 1);
        for (int c = 0; c < 4; c++) ia.wr_data[c] = 8'hFF;
      end
      if (n == 2 || n == 4) ia.swap = 1'b1;
    end
    check("pp done", ia.done, 1);
    step();
    check("pp ack_idle", ia.swap_ack, 1);
    start_a();
    stream_a(2, "neg");

    ia.swap   = 1'b1;
    ia.start  = 1'b1;
    ia.wr_en  = 1'b1;
    ia.wr_row = 2'd0;
    for (int c = 0; c < 4; c++) ia.wr_data[c] = 8'h63;
    step();
    ia.swap  = 1'b0;
    ia.start = 1'b0;
    ia.wr_en = 1'b0;
    check("sim ack", ia.swap_ack, 1);
    check("sim busy", ia.busy, 1);
    stream_a(3, "sim");

    for (int r = 0; r < 4; r++) begin
      ib.wr_en  = 1'b1;
      ib.wr_row = 2'(r);
      for (int c = 0; c < 4; c++) ib.wr_data[c] = (r == 3) ? 8'h77 : 8'(16 * r + c + 1);
      step();
    end
    ib.wr_en = 1'b0;
    ib.swap  = 1'b1;
    step();
    ib.swap  = 1'b0;
    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      check($sformatf("flat c%0d aout", n), ib.Aout, b_tbl[n-1]);
      check($sformatf("flat c%0d vld", n), ib.Aout_vld, 3'b111);
      check($sformatf("flat c%0d done", n), ib.done, (n == 4));
    end
    step();
    check("flat idle vld", ib.Aout_vld, 0);
    check("flat idle busy", ib.busy, 0);

    ib.start = 1'b1;
    step();
    ib.start = 1'b0;
    step();
    step();
    check("abort pre vld", ib.Aout_vld, 3'b111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort aout", ib.Aout, 0);
    check("abort vld", ib.Aout_vld, 0);
    check("abort busy", ib.busy, 0);
    check("abort done", ib.done, 0);
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("abort quiet%0d done", n), ib.done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
